// File: rtl/vector_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vector_exec_unit_pkg
//  Purpose  : Shared opcode and FSM state encodings plus default parameter
//             constants for the vector execution unit and its lane.
//  Revision : 1.0 - initial release
// ============================================================================
package vector_exec_unit_pkg;

    localparam int unsigned c_DEF_VLEN      = 512;
    localparam int unsigned c_DEF_ELEM_W    = 32;
    localparam int unsigned c_DEF_LANES     = 4;
    localparam int unsigned c_DEF_NREG      = 4;
    localparam int unsigned c_DEF_MEM_DEPTH = 512;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_MUL   = 3'b100,
        OP_WRREG = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEM_RD = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/vector_exec_lane.sv
`default_nettype none
// ============================================================================
//  Module   : vector_exec_lane
//  Purpose  : One element-wide arithmetic lane. ADD/SUB wrap modulo
//             2^ELEM_W; MUL yields the full unsigned product split in halves.
//  Ports    : op_i  - opcode (op_e encoding)
//             a_i   - first operand element
//             b_i   - second operand element
//             lo_o  - result / low half of product
//             hi_o  - high half of product (zero for non-MUL ops)
//  Config   : VECTOR_EXEC_UNIT_MUL_EN - when undefined no multiplier exists
//  Revision : 1.0 - initial release
// ============================================================================
module vector_exec_lane
    import vector_exec_unit_pkg::*;
#(
    parameter int unsigned ELEM_W = c_DEF_ELEM_W
) (
    input  logic [2:0]        op_i,
    input  logic [ELEM_W-1:0] a_i,
    input  logic [ELEM_W-1:0] b_i,
    output logic [ELEM_W-1:0] lo_o,
    output logic [ELEM_W-1:0] hi_o
);

`ifdef VECTOR_EXEC_UNIT_MUL_EN
    logic [2*ELEM_W-1:0] w_prod;
    assign w_prod = {{ELEM_W{1'b0}}, a_i} * {{ELEM_W{1'b0}}, b_i};
`endif

    always_comb begin
        lo_o = '0;
        hi_o = '0;
        case (op_i)
            OP_ADD: lo_o = a_i + b_i;
            OP_SUB: lo_o = a_i - b_i;
`ifdef VECTOR_EXEC_UNIT_MUL_EN
            OP_MUL: begin
                lo_o = w_prod[ELEM_W-1:0];
                hi_o = w_prod[2*ELEM_W-1:ELEM_W];
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vector_exec_unit
//  Purpose  : Single-issue vector unit: register file, vector memory and
//             LANES-wide ALU sweeping a vector one element group per cycle.
//  Ports    : clk, rst            - clock, async active-high reset
//             cmd_valid/cmd_ready - command handshake (ready only when idle)
//             cmd_op/rd/ra/rb     - opcode and register specifiers
//             cmd_addr, cmd_data  - memory address, WRREG immediate
//             done, err           - completion pulse, illegal-opcode pulse
//             result              - last vector written to a register/memory
//  Config   : VECTOR_EXEC_UNIT_MUL_EN - enables MUL; otherwise opcode 100 is
//             handled as illegal and no multiplier is built
//  Revision : 1.0 - initial release
// ============================================================================
module vector_exec_unit
    import vector_exec_unit_pkg::*;
#(
    parameter int unsigned VLEN      = c_DEF_VLEN,
    parameter int unsigned ELEM_W    = c_DEF_ELEM_W,
    parameter int unsigned LANES     = c_DEF_LANES,
    parameter int unsigned NREG      = c_DEF_NREG,
    parameter int unsigned MEM_DEPTH = c_DEF_MEM_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [$clog2(NREG)-1:0]      cmd_rd,
    input  logic [$clog2(NREG)-1:0]      cmd_ra,
    input  logic [$clog2(NREG)-1:0]      cmd_rb,
    input  logic [$clog2(MEM_DEPTH)-1:0] cmd_addr,
    input  logic [VLEN-1:0]              cmd_data,
    output logic                         done,
    output logic                         err,
    output logic [VLEN-1:0]              result
);

    localparam int unsigned RW    = $clog2(NREG);
    localparam int unsigned AW    = $clog2(MEM_DEPTH);
    localparam int unsigned GRP_W = ELEM_W * LANES;
    localparam int unsigned NGRP  = VLEN / GRP_W;
    localparam int unsigned GW    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GW-1:0] c_LAST_GRP = GW'(NGRP - 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [RW-1:0]    rd_q;
    logic [AW-1:0]    addr_q;
    logic [VLEN-1:0]  a_q, b_q;
    logic [GW-1:0]    grp_q;
    logic             illegal_q;
    logic [VLEN-1:0]  stage_lo_q;
`ifdef VECTOR_EXEC_UNIT_MUL_EN
    logic [VLEN-1:0]  stage_hi_q;
`endif
    logic             done_q, err_q;
    logic [VLEN-1:0]  result_q;
    logic [VLEN-1:0]  regs_q [NREG];
    logic [VLEN-1:0]  mem_q  [MEM_DEPTH];
    logic [VLEN-1:0]  mem_rdata_q;

    logic             w_is_exec, w_is_legal, w_mem_we;
    logic [31:0]      w_base;
    logic [GRP_W-1:0] w_a_grp, w_b_grp, w_lo_grp, w_hi_grp;

    // ---------------- opcode decode (incoming command) ----------------
    always_comb begin
        w_is_exec  = 1'b0;
        w_is_legal = 1'b1;
        case (cmd_op)
            OP_LOAD, OP_STORE, OP_WRREG: ;
            OP_ADD, OP_SUB:              w_is_exec = 1'b1;
`ifdef VECTOR_EXEC_UNIT_MUL_EN
            OP_MUL:                      w_is_exec = 1'b1;
`endif
            default:                     w_is_legal = 1'b0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!w_is_legal)             state_d = S_WB;
                    else if (cmd_op == OP_LOAD)  state_d = S_MEM_RD;
                    else if (w_is_exec)          state_d = S_EXEC;
                    else                         state_d = S_WB;
                end
            end
            S_MEM_RD: state_d = S_WB;
            S_EXEC:   if (grp_q == c_LAST_GRP) state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);

    // ---------------- lane array on the current element group ----------------
    assign w_base  = {{(32-GW){1'b0}}, grp_q} * GRP_W;
    assign w_a_grp = a_q[w_base +: GRP_W];
    assign w_b_grp = b_q[w_base +: GRP_W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vector_exec_lane #(.ELEM_W(ELEM_W)) u_lane (
            .op_i (op_q),
            .a_i  (w_a_grp [l*ELEM_W +: ELEM_W]),
            .b_i  (w_b_grp [l*ELEM_W +: ELEM_W]),
            .lo_o (w_lo_grp[l*ELEM_W +: ELEM_W]),
            .hi_o (w_hi_grp[l*ELEM_W +: ELEM_W])
        );
    end

`ifndef VECTOR_EXEC_UNIT_MUL_EN
    logic w_unused_hi;
    assign w_unused_hi = ^w_hi_grp;
`endif

    // ---------------- datapath, register file, outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            grp_q      <= '0;
            illegal_q  <= 1'b0;
            stage_lo_q <= '0;
`ifdef VECTOR_EXEC_UNIT_MUL_EN
            stage_hi_q <= '0;
`endif
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // Operands are snapshotted here, so rd may alias ra/rb.
                        op_q       <= cmd_op;
                        rd_q       <= cmd_rd;
                        addr_q     <= cmd_addr;
                        a_q        <= regs_q[cmd_ra];
                        b_q        <= regs_q[cmd_rb];
                        grp_q      <= '0;
                        illegal_q  <= !w_is_legal;
                        // WRREG writes back straight from the staging register.
                        stage_lo_q <= cmd_data;
                    end
                end
                S_EXEC: begin
                    stage_lo_q[w_base +: GRP_W] <= w_lo_grp;
`ifdef VECTOR_EXEC_UNIT_MUL_EN
                    stage_hi_q[w_base +: GRP_W] <= w_hi_grp;
`endif
                    grp_q <= grp_q + GW'(1);
                end
                S_WB: begin
                    done_q <= 1'b1;
                    if (illegal_q) begin
                        err_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_LOAD: begin
                                regs_q[rd_q] <= mem_rdata_q;
                                result_q     <= mem_rdata_q;
                            end
                            OP_STORE: result_q <= a_q;
`ifdef VECTOR_EXEC_UNIT_MUL_EN
                            OP_MUL: begin
                                regs_q[rd_q]          <= stage_lo_q;
                                regs_q[rd_q + RW'(1)] <= stage_hi_q;
                                result_q              <= stage_lo_q;
                            end
`endif
                            default: begin
                                regs_q[rd_q] <= stage_lo_q;
                                result_q     <= stage_lo_q;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is not reset. The read port runs every cycle; for LOAD the value
    // captured on the MEM_RD->WB edge is the one written back.
    assign w_mem_we = (state_q == S_WB) && (op_q == OP_STORE) && !illegal_q;

    always_ff @(posedge clk) begin
        if (w_mem_we) mem_q[addr_q] <= a_q;
        mem_rdata_q <= mem_q[addr_q];
    end

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule
`default_nettype wire
